// File: rtl/tdc_ctrl_pkg.sv
// Shared types and command bytes for the TDC power-up / soft-reset sequencer.
// Sequencer states, UART command byte values and the decoded command bundle.
package tdc_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      EN_LOW    = 2'd1,
      BOOT_WAIT = 2'd2,
      SOFT_RST  = 2'd3
   } state_e;

   localparam logic [7:0] CMD_POWER = 8'h64;  // "d"
   localparam logic [7:0] CMD_HOME  = 8'h68;  // "h"
   localparam logic [7:0] CMD_MASK  = 8'h6D;  // "m"
   localparam logic [7:0] CMD_OFF   = 8'h78;  // "x"
   localparam logic [7:0] CMD_PAUSE = 8'h73;  // "s"
   localparam logic [7:0] CMD_PLAY  = 8'h70;  // "p"

   typedef struct packed {
      logic power;
      logic home;
      logic mask;
      logic off;
      logic pause;
      logic play;
   } cmd_t;

endpackage

// File: rtl/tdc_power_seq_if.sv
// Byte-in / channel-control-out bundle of the TDC power sequencer.
// The master drives UART bytes; the slave (sequencer) drives every other signal.
interface tdc_power_seq_if #(
   parameter int NUM_CH = 6
);
   logic [7:0]        rx_data;
   logic              new_rx_data;
   logic [NUM_CH-1:0] tdc_enable;
   logic [NUM_CH-1:0] soft_reset;
   logic [NUM_CH-1:0] ch_mask;
   logic              busy;
   logic              done;
   logic              go_home;
   logic              pause;

   modport master (
      output rx_data, new_rx_data,
      input  tdc_enable, soft_reset, ch_mask, busy, done, go_home, pause
   );

   modport slave (
      input  rx_data, new_rx_data,
      output tdc_enable, soft_reset, ch_mask, busy, done, go_home, pause
   );
endinterface

// File: rtl/tdc_cmd_decode.sv
// Turns a UART byte strobe into one-hot command pulses, or a mask-load strobe when a mask byte is due.
// "s"/"p" are recognised only when TDC_SEQ_PAUSE_EN is defined.
module tdc_cmd_decode
   import tdc_ctrl_pkg::*;
(
   input  logic [7:0] rx_data,
   input  logic       new_rx_data,
   input  logic       mask_wait,
   output cmd_t       cmd,
   output logic       mask_load
);

   // A pending mask byte is consumed raw and never decoded as a command
   always_comb begin
      cmd       = '0;
      mask_load = 1'b0;
      if (new_rx_data && mask_wait) begin
         mask_load = 1'b1;
      end else if (new_rx_data) begin
         case (rx_data)
            CMD_POWER: cmd.power = 1'b1;
            CMD_HOME:  cmd.home  = 1'b1;
            CMD_MASK:  cmd.mask  = 1'b1;
            CMD_OFF:   cmd.off   = 1'b1;
`ifdef TDC_SEQ_PAUSE_EN
            CMD_PAUSE: cmd.pause = 1'b1;
            CMD_PLAY:  cmd.play  = 1'b1;
`endif
            default:   cmd       = '0;
         endcase
      end else begin
         cmd = '0;
      end
   end

endmodule

// File: rtl/tdc_power_seq.sv
// Parametrised TDC power-up / soft-reset sequencer driven by UART command bytes.
// Optional pause/play commands are enabled by defining TDC_SEQ_PAUSE_EN.
module tdc_power_seq
   import tdc_ctrl_pkg::*;
#(
   parameter int NUM_CH           = 6,
   parameter int CNT_W            = 20,
   parameter int EN_LOW_CYCLES    = 1000,
   parameter int BOOT_CYCLES      = 1048575,
   parameter int RST_PULSE_CYCLES = 4
) (
   input logic            clk,
   input logic            rst,
   tdc_power_seq_if.slave bus
);

   if (NUM_CH < 1 || NUM_CH > 8 || CNT_W < 1 || CNT_W > 30 ||
       EN_LOW_CYCLES < 1 || BOOT_CYCLES < 1 || RST_PULSE_CYCLES < 1 ||
       EN_LOW_CYCLES >= (32'sd1 << CNT_W) || BOOT_CYCLES >= (32'sd1 << CNT_W) ||
       RST_PULSE_CYCLES >= (32'sd1 << CNT_W)) begin : g_bad_params
      $error("tdc_power_seq: parameter out of range");
   end

   localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  EN_LOW_LAST = CNT_W'(EN_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0]  BOOT_LAST   = CNT_W'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  PULSE_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [NUM_CH-1:0] CH_NONE     = {NUM_CH{1'b0}};
   localparam logic [NUM_CH-1:0] CH_ALL      = {NUM_CH{1'b1}};

   state_e            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [NUM_CH-1:0] en_r, en_s;
   logic [NUM_CH-1:0] sr_r, sr_s;
   logic [NUM_CH-1:0] mask_r, mask_s;
   logic [NUM_CH-1:0] seq_mask_r, seq_mask_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic              home_r, home_s;
   logic              wait_r, wait_s;
   cmd_t              cmd_s;
   logic              mask_load_s;

   tdc_cmd_decode u_decode (
      .rx_data     (bus.rx_data),
      .new_rx_data (bus.new_rx_data),
      .mask_wait   (wait_r),
      .cmd         (cmd_s),
      .mask_load   (mask_load_s)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= CNT_ZERO;
         en_r       <= CH_NONE;
         sr_r       <= CH_NONE;
         mask_r     <= CH_ALL;
         seq_mask_r <= CH_ALL;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         home_r     <= 1'b0;
         wait_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         en_r       <= en_s;
         sr_r       <= sr_s;
         mask_r     <= mask_s;
         seq_mask_r <= seq_mask_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         home_r     <= home_s;
         wait_r     <= wait_s;
      end
   end

   // Next-state: "d"/"x" take priority over the running timeline, so a
   // restart on the last pulse cycle suppresses done
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      en_s       = en_r;
      sr_s       = sr_r;
      mask_s     = mask_r;
      seq_mask_s = seq_mask_r;
      busy_s     = busy_r;
      done_s     = 1'b0;
      home_s     = home_r;
      wait_s     = wait_r;

      if (mask_load_s) begin
         mask_s = bus.rx_data[NUM_CH-1:0];
         wait_s = 1'b0;
      end else if (cmd_s.mask) begin
         wait_s = 1'b1;
      end else begin
         wait_s = wait_r;
      end

      if (cmd_s.home) begin
         home_s = 1'b1;
      end else if (cmd_s.power) begin
         home_s = 1'b0;
      end else begin
         home_s = home_r;
      end

      if (cmd_s.power) begin
         state_s    = EN_LOW;
         cnt_s      = CNT_ZERO;
         busy_s     = 1'b1;
         seq_mask_s = mask_r;
         en_s       = en_r & ~mask_r;
         sr_s       = CH_NONE;
      end else if (cmd_s.off) begin
         state_s = IDLE;
         cnt_s   = CNT_ZERO;
         busy_s  = 1'b0;
         en_s    = en_r & ~mask_r;
         sr_s    = CH_NONE;
      end else begin
         case (state_r)
            IDLE: begin
               sr_s   = CH_NONE;
               busy_s = 1'b0;
            end
            EN_LOW: begin
               en_s = en_r & ~seq_mask_r;
               if (cnt_r == EN_LOW_LAST) begin
                  state_s = BOOT_WAIT;
                  cnt_s   = CNT_ZERO;
                  en_s    = en_r | seq_mask_r;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            BOOT_WAIT: begin
               en_s = en_r | seq_mask_r;
               if (cnt_r == BOOT_LAST) begin
                  state_s = SOFT_RST;
                  cnt_s   = CNT_ZERO;
                  sr_s    = seq_mask_r;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            SOFT_RST: begin
               sr_s = seq_mask_r;
               if (cnt_r == PULSE_LAST) begin
                  state_s = IDLE;
                  cnt_s   = CNT_ZERO;
                  sr_s    = CH_NONE;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_s    = IDLE;
               cnt_s      = CNT_ZERO;
               en_s       = CH_NONE;
               sr_s       = CH_NONE;
               mask_s     = CH_ALL;
               seq_mask_s = CH_ALL;
               busy_s     = 1'b0;
               home_s     = 1'b0;
               wait_s     = 1'b0;
            end
         endcase
      end
   end

`ifdef TDC_SEQ_PAUSE_EN
   logic pause_r;

   // Acquisition pause flag set by "s", cleared by "p"
   always_ff @(posedge clk) begin
      if (rst) begin
         pause_r <= 1'b0;
      end else if (cmd_s.pause) begin
         pause_r <= 1'b1;
      end else if (cmd_s.play) begin
         pause_r <= 1'b0;
      end else begin
         pause_r <= pause_r;
      end
   end

   assign bus.pause = pause_r;
`else
   logic unused_pause_s;
   assign unused_pause_s = cmd_s.pause | cmd_s.play;
   assign bus.pause      = 1'b0;
`endif

   assign bus.tdc_enable = en_r;
   assign bus.soft_reset = sr_r;
   assign bus.ch_mask    = mask_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.go_home    = home_r;

endmodule

// File: tb/tb_tdc_power_seq.sv
// Self-checking bench for tdc_power_seq: directed scenarios then random bytes vs. an elapsed-time model.
// Honours TDC_SEQ_PAUSE_EN for the pause expectations.
module tb_tdc_power_seq;

   localparam int NUM_CH = 6;
   localparam int CNT_W  = 20;
   localparam int L      = 3;
   localparam int B      = 10;
   localparam int R      = 4;
   localparam int T_DONE = L + B + R;

   localparam logic [7:0] C_D = 8'h64;
   localparam logic [7:0] C_H = 8'h68;
   localparam logic [7:0] C_M = 8'h6D;
   localparam logic [7:0] C_X = 8'h78;
   localparam logic [7:0] C_S = 8'h73;
   localparam logic [7:0] C_P = 8'h70;

`ifdef TDC_SEQ_PAUSE_EN
   localparam int PAUSE_ON = 1;
`else
   localparam int PAUSE_ON = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   tdc_power_seq_if #(.NUM_CH(NUM_CH)) bus ();

   tdc_power_seq #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .EN_LOW_CYCLES(L),
      .BOOT_CYCLES(B), .RST_PULSE_CYCLES(R)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Model: a running sequence is just "elapsed output cycles since the start command"
   logic [NUM_CH-1:0] m_en, m_mask, m_sm;
   logic              m_wait, m_home, m_pause, m_active, m_done;
   int                m_el;

   task automatic model_step(input logic r, input logic v, input logic [7:0] b);
      logic is_d, is_x;
      is_d   = 1'b0;
      is_x   = 1'b0;
      m_done = 1'b0;
      if (r) begin
         m_en = '0; m_mask = '1; m_sm = '1; m_wait = 1'b0; m_home = 1'b0;
         m_pause = 1'b0; m_active = 1'b0; m_el = 0;
      end else begin
         if (v && m_wait) begin
            m_mask = b[NUM_CH-1:0];
            m_wait = 1'b0;
         end else if (v) begin
            if (b == C_D) is_d = 1'b1;
            else if (b == C_X) is_x = 1'b1;
            else if (b == C_H) m_home = 1'b1;
            else if (b == C_M) m_wait = 1'b1;
`ifdef TDC_SEQ_PAUSE_EN
            else if (b == C_S) m_pause = 1'b1;
            else if (b == C_P) m_pause = 1'b0;
`endif
         end
         if (is_d) begin
            m_active = 1'b1; m_el = 0; m_sm = m_mask; m_home = 1'b0;
         end else if (is_x) begin
            m_active = 1'b0;
            m_en = m_en & ~m_mask;
         end else if (m_active) begin
            m_el = m_el + 1;
            if (m_el == T_DONE) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end
         if (m_active) m_en = (m_el < L) ? (m_en & ~m_sm) : (m_en | m_sm);
      end
   endtask

   task automatic compare();
      logic [NUM_CH-1:0] e_sr;
      e_sr = (m_active && m_el >= L + B) ? m_sm : '0;
      checks++;
      if (bus.tdc_enable !== m_en || bus.soft_reset !== e_sr || bus.ch_mask !== m_mask ||
          bus.busy !== m_active || bus.done !== m_done || bus.go_home !== m_home ||
          bus.pause !== m_pause) begin
         errors++;
         if (errors < 30)
            $display("FAIL model t=%0t: got en=%h sr=%h mask=%h busy=%b done=%b home=%b pause=%b, expected en=%h sr=%h mask=%h busy=%b done=%b home=%b pause=%b",
                     $time, bus.tdc_enable, bus.soft_reset, bus.ch_mask, bus.busy, bus.done,
                     bus.go_home, bus.pause, m_en, e_sr, m_mask, m_active, m_done, m_home, m_pause);
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic v, input logic [7:0] b);
      rst             = r;
      bus.new_rx_data = v;
      bus.rx_data     = b;
      model_step(r, v, b);
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      int ndone;
      logic       rr, vv;
      logic [7:0] bb;
      int         sel;

      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'h00);
      chk("reset_en", bus.tdc_enable, 0);
      chk("reset_mask", bus.ch_mask, 'h3F);
      chk("reset_busy", bus.busy, 0);
      idle(2);

      // Default mask full sequence
      cyc(1'b0, 1'b1, C_D);
      chk("d_en_low", bus.tdc_enable, 0);
      chk("d_busy", bus.busy, 1);
      for (int el = 1; el <= T_DONE + 1; el++) begin
         cyc(1'b0, 1'b0, 8'h00);
         if (el == L - 1) chk("en_still_low", bus.tdc_enable, 0);
         if (el == L) chk("en_rise", bus.tdc_enable, 'h3F);
         if (el == L + B - 1) chk("sr_before", bus.soft_reset, 0);
         if (el == L + B) chk("sr_first", bus.soft_reset, 'h3F);
         if (el == T_DONE - 1) chk("sr_last", bus.soft_reset, 'h3F);
         if (el == T_DONE) begin
            chk("done_pulse", bus.done, 1);
            chk("done_busy", bus.busy, 0);
            chk("done_sr", bus.soft_reset, 0);
         end
         if (el == T_DONE + 1) chk("done_single", bus.done, 0);
      end

      // Mask 0x05: only channels 0 and 2 sequence
      cyc(1'b0, 1'b1, C_M);
      cyc(1'b0, 1'b1, 8'h05);
      cyc(1'b0, 1'b1, C_D);
      chk("mask5_en_low", bus.tdc_enable, 'h3A);
      for (int el = 1; el <= T_DONE + 1; el++) begin
         cyc(1'b0, 1'b0, 8'h00);
         if (el == L + B) chk("mask5_sr", bus.soft_reset, 'h05);
      end

      // "d" as mask byte: no sequence
      cyc(1'b0, 1'b1, C_M);
      cyc(1'b0, 1'b1, C_D);
      chk("mask_d_val", bus.ch_mask, 'h24);
      chk("mask_d_busy", bus.busy, 0);
      cyc(1'b0, 1'b1, C_M);
      cyc(1'b0, 1'b1, 8'hFF);
      chk("mask_restore", bus.ch_mask, 'h3F);

      // Restart mid BOOT_WAIT
      cyc(1'b0, 1'b1, C_D);
      idle(5);
      cyc(1'b0, 1'b1, C_D);
      chk("restart_en_low", bus.tdc_enable, 0);
      ndone = 0;
      for (int i = 0; i < 25; i++) begin
         cyc(1'b0, 1'b0, 8'h00);
         ndone += int'(bus.done);
      end
      chk("restart_one_done", ndone, 1);

      // go_home and abort
      cyc(1'b0, 1'b1, C_H);
      chk("home_set", bus.go_home, 1);
      cyc(1'b0, 1'b1, C_D);
      chk("home_clear", bus.go_home, 0);
      idle(5);
      cyc(1'b0, 1'b1, C_X);
      chk("off_en", bus.tdc_enable, 0);
      chk("off_busy", bus.busy, 0);
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b0, 8'h00);
         ndone += int'(bus.done);
      end
      chk("off_no_done", ndone, 0);

      // Pause / play
      cyc(1'b0, 1'b1, C_S);
      chk("pause_s", bus.pause, PAUSE_ON);
      cyc(1'b0, 1'b1, C_P);
      chk("pause_p", bus.pause, 0);

      // rst mid SOFT_RST
      cyc(1'b0, 1'b1, C_M);
      cyc(1'b0, 1'b1, 8'h0F);
      cyc(1'b0, 1'b1, C_D);
      cyc(1'b0, 1'b1, C_H);
      idle(L + B + 1 - 2);
      chk("pre_rst_sr", bus.soft_reset, 'h0F);
      cyc(1'b1, 1'b0, 8'h00);
      chk("rst_en", bus.tdc_enable, 0);
      chk("rst_sr", bus.soft_reset, 0);
      chk("rst_mask", bus.ch_mask, 'h3F);
      chk("rst_busy", bus.busy, 0);
      chk("rst_home", bus.go_home, 0);
      chk("rst_pause", bus.pause, 0);

      // Random byte stream
      for (int i = 0; i < 4000; i++) begin
         rr  = ($urandom_range(0, 299) == 0);
         vv  = ($urandom_range(0, 5) == 0);
         sel = $urandom_range(0, 9);
         case (sel)
            0: bb = C_D;
            1: bb = C_H;
            2: bb = C_M;
            3: bb = C_X;
            4: bb = C_S;
            5: bb = C_P;
            default: bb = 8'($urandom_range(0, 255));
         endcase
         cyc(rr, vv, bb);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
